// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high {g..a} patterns and pin polarity helper.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_A     = 7'h77;
  localparam seg7_t SEG_B     = 7'h7C;
  localparam seg7_t SEG_C     = 7'h39;
  localparam seg7_t SEG_D     = 7'h5E;
  localparam seg7_t SEG_E     = 7'h79;
  localparam seg7_t SEG_F     = 7'h71;
  localparam seg7_t SEG_BLANK = 7'h00;

  // Per-bit so it serves any pin-vector width (segments and anodes alike).
  function automatic logic to_pin(input logic active, input bit active_low);
    return active_low ? ~active : active;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-high {g..a} pattern; codes 10..15 need hex_mode.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output seg7_t      pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: pattern = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: pattern = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: pattern = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: pattern = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: pattern = hex_mode ? SEG_F : SEG_BLANK;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame snapshot,
// hex mode and leading-zero blanking; all pins registered.
module sevenseg_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam bit POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{POL_LOW}};
  localparam logic [7:0]          SEG_OFF = {8{POL_LOW}};

  typedef enum logic {ST_START, ST_SCAN} scan_state_t;

  scan_state_t           state, state_next;
  logic [PRE_W-1:0]      pre_cnt, pre_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic                  tick, snap;
  logic [4*N_DIGITS-1:0] dig_q, dig_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic                  hex_q, hex_d, blz_q, blz_d;
  logic [N_DIGITS-1:0]   blank;
  logic                  zero_run, dp_run;
  logic [3:0]            sel_code;
  seg7_t                 sel_pat;
  logic [N_DIGITS-1:0]   an_raw, anode_d;
  logic [7:0]            seg_raw, seg_d;

  // ST_START holds the prescaler for one cycle so digit 0 still gets a full slot.
  always_comb begin
    state_next = state;
    pre_next   = pre_cnt;
    idx_next   = idx;
    snap       = 1'b0;
    tick       = (pre_cnt == PRE_LAST);
    case (state)
      ST_START: begin
        state_next = ST_SCAN;
        snap       = 1'b1;
      end
      ST_SCAN: begin
        if (tick) begin
          pre_next = '0;
          if (idx == IDX_LAST) begin
            idx_next = '0;
            snap     = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else begin
          pre_next = pre_cnt + 1'b1;
        end
      end
      default: state_next = ST_START;
    endcase
  end

  assign dig_d = snap ? digits_in : dig_q;
  assign dp_d  = snap ? dp_in     : dp_q;
  assign hex_d = snap ? hex_mode  : hex_q;
  assign blz_d = snap ? blank_lz  : blz_q;

  // Walk from the most-significant digit down; any dp at or above a digit unblanks it.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    dp_run   = 1'b0;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (dig_d[4*i +: 4] == 4'd0);
      dp_run   = dp_run | dp_d[i];
      blank[i] = blz_d & zero_run & ~dp_run;
    end
  end

  assign sel_code = dig_d[{idx_next, 2'b00} +: 4];

  seg7_decode u_decode (
    .code     (sel_code),
    .hex_mode (hex_d),
    .pattern  (sel_pat)
  );

  always_comb begin
    an_raw           = '0;
    an_raw[idx_next] = 1'b1;
    seg_raw          = blank[idx_next] ? 8'h00 : {dp_d[idx_next], sel_pat};
    for (int unsigned i = 0; i < N_DIGITS; i++) anode_d[i] = to_pin(an_raw[i], POL_LOW);
    for (int unsigned i = 0; i < 8; i++) seg_d[i] = to_pin(seg_raw[i], POL_LOW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_START;
      pre_cnt     <= '0;
      idx         <= '0;
      dig_q       <= '0;
      dp_q        <= '0;
      hex_q       <= 1'b0;
      blz_q       <= 1'b0;
      anode       <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      pre_cnt     <= pre_next;
      idx         <= idx_next;
      dig_q       <= dig_d;
      dp_q        <= dp_d;
      hex_q       <= hex_d;
      blz_q       <= blz_d;
      anode       <= anode_d;
      seg         <= seg_d;
      frame_start <= snap;
    end
  end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Parametrised, time-multiplexed driver for an N-digit seven-segment display. It takes a packed vector of N 4-bit digit codes plus per-digit decimal points, snapshots them once per scan frame, and cycles one digit enable at a time at a programmable refresh rate. Each digit is decoded through the shared segment decoder, with optional hex mode and leading-zero blanking. It sits between the datapath result registers and the board display pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned (2..8).
- `REFRESH_DIV`, 100000: `clk` cycles each digit stays enabled (≥2).
- `ACTIVE_LOW`, 1: 1 means segment and anode pins are active-low; 0 means active-high.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `digits_in`  in  4*N_DIGITS  digit codes; digit 0 is `[3:0]`, the rightmost digit.
- `dp_in`  in  N_DIGITS  decimal point request per digit.
- `hex_mode`  in  1  1 decodes codes 10..15 as A,b,C,d,E,F; 0 blanks codes 10..15.
- `blank_lz`  in  1  1 enables leading-zero blanking.
- `anode`  out  N_DIGITS  digit enables, one-hot active (polarity per `ACTIVE_LOW`).
- `seg`  out  8  `{dp,g,f,e,d,c,b,a}` (polarity per `ACTIVE_LOW`).
- `frame_start`  out  1  one-cycle pulse when digit 0 becomes active and the snapshot is taken.

## Operation
- Prescaler `pre_cnt` counts 0..`REFRESH_DIV`-1 and wraps. `tick` is asserted when `pre_cnt == REFRESH_DIV-1`.
- On `tick`, digit index `idx` advances by 1 and wraps from N_DIGITS-1 to 0.
- Snapshot registers capture `digits_in`, `dp_in`, `hex_mode` and `blank_lz` on the `tick` where `idx` wraps to 0. Digit data is never taken from the live inputs mid-frame, so a frame cannot mix old and new values.
- The first snapshot is taken in the first cycle after reset release. `frame_start` pulses in that cycle.
- Leading-zero blanking, when the snapshot `blank_lz` is 1:
  - Digit k is blanked if its code and every more-significant digit code are all 0.
  - Digit 0 is never blanked.
  - A blanked digit also drops its dp, except that dp on a blanked digit forces that digit and all lower digits to unblank.
- Decoding:
  - Codes 0..9 give the standard patterns: 0 → `7'h3F`, 1 → `7'h06`, 8 → `7'h7F` in active-high `{g..a}` form.
  - Codes 10..15 decode as A–F when the snapshot `hex_mode` is 1, otherwise blank.
- `anode` enables only bit `idx`. `seg` shows the decoded pattern of snapshot digit `idx`.
- Active-low polarity is applied as a final inversion.

## Timing
- `anode`, `seg` and `frame_start` are registered outputs.
- A change of `idx` appears on the pins one cycle after `tick`. Anode and segments update in the same cycle, so there are no ghosting glitches.
- Each digit stays enabled for exactly `REFRESH_DIV` cycles. A frame lasts `N_DIGITS*REFRESH_DIV` cycles.
- Input-to-display latency is up to one frame plus one cycle.
- Reset (async assert, sync release):
  - `pre_cnt` = 0, `idx` = 0, snapshots cleared to 0.
  - `anode` and `seg` are all inactive (all 1s when `ACTIVE_LOW`=1).
  - `frame_start` = 0.
- Reset mid-frame returns to this state immediately; no partial digit time is carried over.
- Input changes coinciding with the snapshot `tick` are captured, since they are sampled at that edge.

## Structure
- Package `seg7_pkg`:
  - segment pattern constants `SEG_0..SEG_F` and `SEG_BLANK`;
  - typedef `seg7_t` (logic [6:0]);
  - function for polarity inversion.
- Sub-module `seg7_decode`: combinational 4-bit code + `hex_mode` → `seg7_t`. It is instantiated once and muxed by `idx`.
- The top level contains the prescaler, index counter, snapshot registers, blanking logic and output registers.

## Test plan
Bench parameters: `N_DIGITS`=4, `REFRESH_DIV`=4, `ACTIVE_LOW`=1.
- **Reset values:** hold `reset`=1 → `anode`=4'b1111, `seg`=8'hFF. After release, `frame_start` pulses once, then `anode` steps 1110 → 1101 → 1011 → 0111, each held 4 cycles.
- **Plain decode:** `digits_in`=16'h1234, `blank_lz`=0, `dp_in`=0. When `anode`=1110, `seg`=~{1'b0,7'h66} (digit 4); when `anode`=0111, `seg`=~{1'b0,7'h06} (digit 1).
- **Hex mode:** `digits_in`=16'h00AF.
  - With `hex_mode`=1, digit 0 shows ~`7'h71` (F).
  - With `hex_mode`=0, digits 0 and 1 show 8'hFF.
- **Leading-zero blanking:** `digits_in`=16'h0050, `blank_lz`=1 → digits 3 and 2 give `seg`=8'hFF; digit 1 shows 5; digit 0 shows 0.
  - Add `dp_in`=4'b0100 → digit 2 shows "0." (`seg`=~8'hBF).
- **Frame atomicity:** change `digits_in` from 16'h1111 to 16'h2222 while digit 2 is active → digit 3 still shows 1 for the rest of that frame; all digits show 2 from the next `frame_start`.
- **Reset mid-operation:** assert `reset` for 1 cycle while `idx`=2 → outputs go inactive immediately. After release, the scan restarts at digit 0 with full 4-cycle digit times and a new snapshot.
